// File: rtl/rdp_sched_pkg.sv
// Shared types and constants for the RDP systolic XOR stripe sequencer.
package rdp_sched_pkg;

    localparam int unsigned W_DEF     = 512;
    localparam int unsigned CNT_W_DEF = 16;

    localparam int unsigned NUM_LANES = 5;
    localparam int unsigned K8        = 0;
    localparam int unsigned K9        = 1;
    localparam int unsigned K10       = 2;
    localparam int unsigned K11       = 3;
    localparam int unsigned C         = 4;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

endpackage

// File: rtl/rdp_lane_buf.sv
// One-entry holding buffer for a single input lane; a load overrides a same-cycle clear.
module rdp_lane_buf #(
    parameter int unsigned W = 512
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_dat,
    input  logic         in_vld,
    input  logic         load,
    input  logic         clear,
    output logic [W-1:0] out_dat,
    output logic         full
);

    logic [W-1:0] dat_q, dat_d;
    logic         full_q, full_d;

    always_comb begin
        dat_d  = dat_q;
        full_d = full_q;
        if (clear) begin
            dat_d  = '0;
            full_d = 1'b0;
        end
        // Refill in the issue cycle: the new beat replaces the one being consumed.
        if (load && in_vld) begin
            dat_d  = in_dat;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dat_q  <= '0;
            full_q <= 1'b0;
        end else begin
            dat_q  <= dat_d;
            full_q <= full_d;
        end
    end

    assign out_dat = dat_q;
    assign full    = full_q;

endmodule

// File: rtl/rdp_stripe_sched.sv
// Aligns five handshaked lanes beat by beat and issues k1 = k8^k9^c, k2 = k10^k11^c per stripe.
module rdp_stripe_sched
    import rdp_sched_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_beats,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    input  logic [W-1:0]     t_k8_dat,
    input  logic [W-1:0]     t_k9_dat,
    input  logic [W-1:0]     t_k10_dat,
    input  logic [W-1:0]     t_k11_dat,
    input  logic [W-1:0]     t_c_dat,
    input  logic             t_k8_vld,
    input  logic             t_k9_vld,
    input  logic             t_k10_vld,
    input  logic             t_k11_vld,
    input  logic             t_c_vld,
    output logic             t_k8_rdy,
    output logic             t_k9_rdy,
    output logic             t_k10_rdy,
    output logic             t_k11_rdy,
    output logic             t_c_rdy,
    output logic [W-1:0]     i_k1_dat,
    output logic [W-1:0]     i_k2_dat,
    output logic             i_vld,
    input  logic             i_rdy,
    output logic             i_last
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [W-1:0]     k1_q, k1_d, k2_q, k2_d;
    logic             vld_q, vld_d, last_q, last_d, done_q, done_d;

    logic [W-1:0]         lane_in  [NUM_LANES];
    logic [W-1:0]         lane_dat [NUM_LANES];
    logic [NUM_LANES-1:0] lane_vld, lane_rdy, lane_full;
    logic                 run, fire, out_hs;

    assign lane_in[K8]  = t_k8_dat;
    assign lane_in[K9]  = t_k9_dat;
    assign lane_in[K10] = t_k10_dat;
    assign lane_in[K11] = t_k11_dat;
    assign lane_in[C]   = t_c_dat;
    assign lane_vld     = {t_c_vld, t_k11_vld, t_k10_vld, t_k9_vld, t_k8_vld};

    assign run    = (state_q == RUN);
    assign fire   = run && (&lane_full) && (!vld_q || i_rdy);
    assign out_hs = vld_q && i_rdy;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        // remaining counts unissued sets, so a lane with an empty buffer is always owed a beat.
        assign lane_rdy[g] = run && ((!lane_full[g] && rem_q != '0) || (fire && rem_q > CntOne));

        rdp_lane_buf #(.W(W)) u_buf (
            .clk     (clk),
            .reset   (reset),
            .in_dat  (lane_in[g]),
            .in_vld  (lane_vld[g]),
            .load    (lane_rdy[g] && !abort),
            .clear   (fire || abort),
            .out_dat (lane_dat[g]),
            .full    (lane_full[g])
        );
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        k1_d    = k1_q;
        k2_d    = k2_q;
        vld_d   = vld_q;
        last_d  = last_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            rem_d   = '0;
            k1_d    = '0;
            k2_d    = '0;
            vld_d   = 1'b0;
            last_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (num_beats != '0) begin
                            state_d = RUN;
                            rem_d   = num_beats;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fire && rem_q == CntOne) state_d = DRAIN;
                end
                DRAIN: begin
                    if (out_hs && last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (fire) begin
                k1_d   = lane_dat[K8] ^ lane_dat[K9] ^ lane_dat[C];
                k2_d   = lane_dat[K10] ^ lane_dat[K11] ^ lane_dat[C];
                vld_d  = 1'b1;
                last_d = (rem_q == CntOne);
                rem_d  = rem_q - CntOne;
            end else if (out_hs) begin
                vld_d  = 1'b0;
                last_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign i_k1_dat  = k1_q;
    assign i_k2_dat  = k2_q;
    assign i_vld     = vld_q;
    assign i_last    = last_q;
    assign t_k8_rdy  = lane_rdy[K8];
    assign t_k9_rdy  = lane_rdy[K9];
    assign t_k10_rdy = lane_rdy[K10];
    assign t_k11_rdy = lane_rdy[K11];
    assign t_c_rdy   = lane_rdy[C];

endmodule

// File: tb/tb_rdp_stripe_sched.sv
// Randomized self-checking bench for rdp_stripe_sched against a stripe-level XOR model.
module tb_rdp_stripe_sched;

    localparam int W     = 512;
    localparam int CNT_W = 16;
    localparam int MAXB  = 16;

    logic             clk = 1'b0;
    logic             reset, start, abort, i_rdy;
    logic [CNT_W-1:0] num_beats;
    logic [W-1:0]     dat [5];
    logic             vld [5];
    logic             rdy [5];
    logic             busy, done, i_vld, i_last;
    logic [W-1:0]     k1, k2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rdp_stripe_sched #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_beats (num_beats),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .t_k8_dat  (dat[0]),
        .t_k9_dat  (dat[1]),
        .t_k10_dat (dat[2]),
        .t_k11_dat (dat[3]),
        .t_c_dat   (dat[4]),
        .t_k8_vld  (vld[0]),
        .t_k9_vld  (vld[1]),
        .t_k10_vld (vld[2]),
        .t_k11_vld (vld[3]),
        .t_c_vld   (vld[4]),
        .t_k8_rdy  (rdy[0]),
        .t_k9_rdy  (rdy[1]),
        .t_k10_rdy (rdy[2]),
        .t_k11_rdy (rdy[3]),
        .t_c_rdy   (rdy[4]),
        .i_k1_dat  (k1),
        .i_k2_dat  (k2),
        .i_vld     (i_vld),
        .i_rdy     (i_rdy),
        .i_last    (i_last)
    );

    function automatic logic [W-1:0] rnd_beat();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic int any_rdy();
        int n = 0;
        for (int l = 0; l < 5; l++) if (rdy[l] === 1'b1) n++;
        return n;
    endfunction

    task automatic drive_idle();
        start = 1'b0;
        abort = 1'b0;
        for (int l = 0; l < 5; l++) begin
            vld[l] = 1'b0;
            dat[l] = '0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if (any_rdy() != 0 || i_vld !== 1'b0 || i_last !== 1'b0 || busy !== 1'b0
            || done !== 1'b0 || k1 !== '0 || k2 !== '0) begin
            bad++;
            $display("FAIL %s: rdy_cnt=%0d vld=%b last=%b busy=%b done=%b k1_zero=%b k2_zero=%b, required all 0",
                     tag, any_rdy(), i_vld, i_last, busy, done, k1 == '0, k2 == '0);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        i_rdy     = 1'b0;
        num_beats = '0;
        reset     = 1'b1;
        #12;
        check_reset_outputs("reset_in");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("reset_out");
    endtask

    task automatic test_single();
        @(negedge clk);
        start = 1'b1;
        num_beats = 1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
        dat[0] = 512'h01; dat[1] = 512'h02; dat[2] = 512'h04; dat[3] = 512'h08; dat[4] = 512'h10;
        for (int l = 0; l < 5; l++) vld[l] = 1'b1;
        i_rdy = 1'b1;
        #1;
        total++;
        if (any_rdy() != 5) begin bad++; $display("FAIL single_rdy: got %0d ready lanes want 5", any_rdy()); end
        @(negedge clk);
        for (int l = 0; l < 5; l++) vld[l] = 1'b0;
        #1;
        total++;
        if (i_vld !== 1'b0) begin bad++; $display("FAIL single_early: i_vld=%b want 0", i_vld); end
        @(negedge clk);
        #1;
        total++;
        if (i_vld !== 1'b1 || i_last !== 1'b1 || k1 !== 512'h13 || k2 !== 512'h1c || done !== 1'b0) begin
            bad++;
            $display("FAIL single_out: vld=%b last=%b k1=%h k2=%h done=%b want 1 1 13 1c 0",
                     i_vld, i_last, k1[31:0], k2[31:0], done);
        end
        @(negedge clk);
        #1;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || i_vld !== 1'b0) begin
            bad++;
            $display("FAIL single_done: done=%b busy=%b vld=%b want 1 0 0", done, busy, i_vld);
        end
        @(negedge clk);
        #1;
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL single_done_pulse: done=%b want 0", done); end
    endtask

    // vmode: 0 random valid, 1 always valid. rmode: 0 random, 1 always, 2 toggle 1010.
    task automatic run_stripe(input int n, input int vmode, input int rmode, input int skew_c,
                              input string name);
        logic [W-1:0] mem [5][MAXB];
        int  idx [5];
        bit  hs [5];
        int  outc = 0, first_out = -1, last_out = -1;
        bit  expect_done = 1'b0, done_seen = 1'b0;
        logic [W-1:0] e1, e2;
        for (int l = 0; l < 5; l++) begin
            idx[l] = 0;
            for (int b = 0; b < MAXB; b++) mem[l][b] = rnd_beat();
        end
        @(negedge clk);
        start = 1'b1;
        num_beats = CNT_W'(n);
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int l = 0; l < 5; l++) begin
                vld[l] = (cyc >= (l == 4 ? skew_c : 0)) && (vmode == 1 || ($urandom % 2) == 1);
                dat[l] = (idx[l] < n) ? mem[l][idx[l]] : rnd_beat();
            end
            i_rdy = (rmode == 1) ? 1'b1 : (rmode == 2) ? (cyc % 2 == 0) : (($urandom % 2) == 1);
            #1;
            total++;
            if (done !== expect_done) begin
                bad++;
                $display("FAIL %s_done: cyc=%0d done=%b want %b", name, cyc, done, expect_done);
            end
            if (done === 1'b1) done_seen = 1'b1;
            expect_done = 1'b0;
            if (done_seen) break;
            if (idx[4] == 0 && i_vld === 1'b1) begin
                total++;
                bad++;
                $display("FAIL %s_early: output before c lane arrived, cyc=%0d", name, cyc);
            end
            for (int l = 0; l < 5; l++) begin
                hs[l] = (vld[l] && rdy[l] === 1'b1);
                if (hs[l] && idx[l] >= n) begin
                    total++;
                    bad++;
                    $display("FAIL %s_overaccept: lane %0d beat %0d of %0d", name, l, idx[l], n);
                end
            end
            if (i_vld === 1'b1 && i_rdy) begin
                e1 = mem[0][outc] ^ mem[1][outc] ^ mem[4][outc];
                e2 = mem[2][outc] ^ mem[3][outc] ^ mem[4][outc];
                total++;
                if (k1 !== e1 || k2 !== e2 || i_last !== (outc == n - 1)) begin
                    bad++;
                    $display("FAIL %s_beat%0d: k1=%h k2=%h last=%b want k1=%h k2=%h last=%b", name,
                             outc, k1[31:0], k2[31:0], i_last, e1[31:0], e2[31:0], outc == n - 1);
                end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                outc++;
                if (outc == n) expect_done = 1'b1;
            end
            @(posedge clk);
            for (int l = 0; l < 5; l++) if (hs[l] && idx[l] < n) idx[l]++;
            @(negedge clk);
        end
        drive_idle();
        total++;
        if (!done_seen || outc != n) begin
            bad++;
            $display("FAIL %s_complete: done_seen=%b beats=%0d want 1 %0d", name, done_seen, outc, n);
        end
        for (int l = 0; l < 5; l++) begin
            total++;
            if (idx[l] != n) begin
                bad++;
                $display("FAIL %s_lane%0d_count: got %0d want %0d", name, l, idx[l], n);
            end
        end
        if (vmode == 1 && rmode == 1) begin
            total++;
            if (last_out - first_out != n - 1) begin
                bad++;
                $display("FAIL %s_rate: span=%0d cycles want %0d", name, last_out - first_out, n - 1);
            end
        end
        @(negedge clk);
        #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle: done=%b busy=%b want 0 0", name, done, busy);
        end
    endtask

    task automatic test_streaming();
        run_stripe(8, 1, 1, 0, "stream");
    endtask

    task automatic test_skew_backpressure();
        run_stripe(6, 1, 2, 5, "skew");
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) run_stripe(1 + int'($urandom % MAXB), 0, 0, int'($urandom % 4), "rand");
    endtask

    task automatic test_zero_length();
        @(negedge clk);
        start = 1'b1;
        num_beats = '0;
        for (int l = 0; l < 5; l++) vld[l] = 1'b1;
        i_rdy = 1'b1;
        #1;
        total++;
        if (any_rdy() != 0) begin bad++; $display("FAIL zero_rdy0: got %0d ready lanes want 0", any_rdy()); end
        @(negedge clk);
        start = 1'b0;
        #1;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || any_rdy() != 0) begin
            bad++;
            $display("FAIL zero_done: done=%b busy=%b rdy_cnt=%0d want 1 0 0", done, busy, any_rdy());
        end
        @(negedge clk);
        #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || any_rdy() != 0) begin
            bad++;
            $display("FAIL zero_after: done=%b busy=%b rdy_cnt=%0d want 0 0 0", done, busy, any_rdy());
        end
        drive_idle();
    endtask

    task automatic test_abort();
        int outs = 0;
        @(negedge clk);
        start = 1'b1;
        num_beats = 4;
        @(negedge clk);
        start = 1'b0;
        i_rdy = 1'b1;
        for (int cyc = 0; cyc < 50 && outs < 2; cyc++) begin
            for (int l = 0; l < 5; l++) begin
                vld[l] = 1'b1;
                dat[l] = rnd_beat();
            end
            #1;
            if (i_vld === 1'b1) outs++;
            @(negedge clk);
        end
        total++;
        if (outs != 2) begin bad++; $display("FAIL abort_setup: got %0d outputs want 2", outs); end
        i_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int l = 0; l < 5; l++) vld[l] = 1'b0;
        #1;
        total++;
        if (i_vld !== 1'b0 || i_last !== 1'b0 || busy !== 1'b0 || k1 !== '0 || k2 !== '0 || any_rdy() != 0) begin
            bad++;
            $display("FAIL abort_state: vld=%b last=%b busy=%b rdy_cnt=%0d want all 0",
                     i_vld, i_last, busy, any_rdy());
        end
        for (int c = 0; c < 3; c++) begin
            total++;
            if (done !== 1'b0) begin bad++; $display("FAIL abort_done: done=%b want 0", done); end
            @(negedge clk);
            #1;
        end
        run_stripe(1, 1, 1, 0, "post_abort");
    endtask

    task automatic test_async_reset();
        bool_wait: begin end
        @(negedge clk);
        start = 1'b1;
        num_beats = 1;
        @(negedge clk);
        start = 1'b0;
        i_rdy = 1'b0;
        for (int l = 0; l < 5; l++) begin
            vld[l] = 1'b1;
            dat[l] = rnd_beat();
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (i_vld === 1'b1) break;
            @(negedge clk);
        end
        for (int l = 0; l < 5; l++) vld[l] = 1'b0;
        total++;
        if (i_vld !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL areset_setup: vld=%b busy=%b want 1 1", i_vld, busy);
        end
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("areset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_streaming();
        test_skew_backpressure();
        test_zero_length();
        test_random();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
